// File: rtl/axis_red_pitaya_adc_avg.sv
// Multi-channel ADC front end: offset-binary decode, 2^N boxcar average, AXI4-Stream master output.
// Optional ADC_RANDOMIZER_EN adds the LTC-style output randomizer decode ahead of stage 1.
module axis_red_pitaya_adc_avg #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned ADC_WIDTH    = 16,
  parameter int unsigned MAX_LOG2_DEC = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  output logic                            adc_csn,
  input  logic [CHANNELS*ADC_WIDTH-1:0]   adc_dat,
  input  logic [3:0]                      cfg_log2_dec,
  input  logic                            cfg_offset_bin,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tvalid,
  output logic [CHANNELS*ADC_WIDTH-1:0]   m_axis_tdata,
  output logic                            sts_overrun,
  output logic [CNT_WIDTH-1:0]            sts_overrun_cnt
);

  localparam int unsigned AccWidth = ADC_WIDTH + MAX_LOG2_DEC;
  localparam int unsigned WinWidth = (MAX_LOG2_DEC > 0) ? MAX_LOG2_DEC : 1;

  logic [CHANNELS*ADC_WIDTH-1:0] smp_d, smp_q;
  logic                          smp_vld_q;
  logic [ADC_WIDTH-1:0]          word;

  logic [3:0]                    nl_cfg, nl_q, nl;
  logic [WinWidth-1:0]           cnt_q, last_cnt;
  logic                          last, new_res;

  logic signed [AccWidth-1:0]    acc_q [CHANNELS];
  logic signed [AccWidth-1:0]    sum_d [CHANNELS];
  logic signed [AccWidth-1:0]    shifted;
  logic [CHANNELS*ADC_WIDTH-1:0] res_d;

  assign adc_csn = 1'b1;

  always_comb begin
    smp_d = '0;
    word  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      word = adc_dat[c*ADC_WIDTH +: ADC_WIDTH];
`ifdef ADC_RANDOMIZER_EN
      word = word ^ {{(ADC_WIDTH-1){word[0]}}, 1'b0};
`endif
      if (cfg_offset_bin) word[ADC_WIDTH-1] = ~word[ADC_WIDTH-1];
      smp_d[c*ADC_WIDTH +: ADC_WIDTH] = word;
    end
  end

  // Stage 1: smp_vld_q keeps the reset value of smp_q out of the first window.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      smp_q     <= '0;
      smp_vld_q <= 1'b0;
    end else begin
      smp_q     <= smp_d;
      smp_vld_q <= 1'b1;
    end
  end

  // The window length is sampled only on the first sample of a window.
  always_comb begin
    nl_cfg = ({28'd0, cfg_log2_dec} > MAX_LOG2_DEC) ? 4'(MAX_LOG2_DEC) : cfg_log2_dec;
    nl     = (cnt_q == '0) ? nl_cfg : nl_q;
    last_cnt = '0;
    for (int i = 0; i < WinWidth; i++) last_cnt[i] = (i < int'(nl));
    last    = (cnt_q == last_cnt);
    new_res = smp_vld_q && last;
  end

  always_comb begin
    res_d   = '0;
    shifted = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_d[c] = ((cnt_q == '0) ? AccWidth'(0) : acc_q[c])
               + AccWidth'($signed(smp_q[c*ADC_WIDTH +: ADC_WIDTH]));
      shifted  = sum_d[c] >>> nl;
      res_d[c*ADC_WIDTH +: ADC_WIDTH] = shifted[ADC_WIDTH-1:0];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
      nl_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else if (smp_vld_q) begin
      if (cnt_q == '0) nl_q <= nl_cfg;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= sum_d[c];
      cnt_q <= last ? '0 : cnt_q + WinWidth'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid   <= 1'b0;
      m_axis_tdata    <= '0;
      sts_overrun     <= 1'b0;
      sts_overrun_cnt <= '0;
    end else if (new_res) begin
      m_axis_tdata  <= res_d;
      m_axis_tvalid <= 1'b1;
      if (m_axis_tvalid && !m_axis_tready) begin
        sts_overrun <= 1'b1;
        if (sts_overrun_cnt != '1) sts_overrun_cnt <= sts_overrun_cnt + CNT_WIDTH'(1);
      end
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_red_pitaya_adc_avg.sv
// Randomized bench for axis_red_pitaya_adc_avg against a window-average reference model.
module tb_axis_red_pitaya_adc_avg;
  localparam int CH = 2;
  localparam int W  = 16;
  localparam int MAXL = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            adc_csn;
  logic [CH*W-1:0] adc_dat;
  logic [3:0]      cfg_log2_dec;
  logic            cfg_offset_bin;
  logic            tready;
  logic            tvalid;
  logic [CH*W-1:0] tdata;
  logic            ovr;
  logic [15:0]     ovr_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  longint sums [CH];
  int     win_len;
  int     win_n;
  longint pend [CH];
  bit     pend_v;
  bit     m_valid;
  logic [CH*W-1:0] m_data;
  bit     m_ovr;
  int     m_ovr_cnt;

  axis_red_pitaya_adc_avg dut (
    .aclk            (clk),
    .aresetn         (rst_n),
    .adc_csn         (adc_csn),
    .adc_dat         (adc_dat),
    .cfg_log2_dec    (cfg_log2_dec),
    .cfg_offset_bin  (cfg_offset_bin),
    .m_axis_tready   (tready),
    .m_axis_tvalid   (tvalid),
    .m_axis_tdata    (tdata),
    .sts_overrun     (ovr),
    .sts_overrun_cnt (ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint decode(input logic [W-1:0] raw, input bit ob);
    logic [W-1:0] v;
    v = raw;
`ifdef ADC_RANDOMIZER_EN
    if (v[0]) v = v ^ 16'hFFFE;
`endif
    if (ob) v = v ^ 16'h8000;
    return longint'($signed(v));
  endfunction

  function automatic longint floor_div(input longint a, input int n);
    longint d, q;
    d = longint'(1) << n;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      sums[c] = 0;
      pend[c] = 0;
    end
    win_len = 0; win_n = 0; pend_v = 0;
    m_valid = 0; m_data = '0; m_ovr = 0; m_ovr_cnt = 0;
  endfunction

  // One rising edge: the previously captured sample enters its window, the pins are captured.
  function automatic void model_edge(input logic [CH*W-1:0] pins, input int cfg, input bit ob,
                                     input bit rdy);
    bit new_res;
    logic [CH*W-1:0] res;
    logic [W-1:0] avg;
    new_res = 0;
    res = '0;
    if (pend_v) begin
      if (win_len == 0) begin
        win_n = (cfg > MAXL) ? MAXL : cfg;
        for (int c = 0; c < CH; c++) sums[c] = 0;
      end
      for (int c = 0; c < CH; c++) sums[c] += pend[c];
      win_len++;
      if (win_len == (1 << win_n)) begin
        new_res = 1;
        for (int c = 0; c < CH; c++) begin
          avg = W'(floor_div(sums[c], win_n));
          res[c*W +: W] = avg;
        end
        win_len = 0;
      end
    end
    if (new_res) begin
      if (m_valid && !rdy) begin
        m_ovr = 1;
        if (m_ovr_cnt < 65535) m_ovr_cnt++;
      end
      m_valid = 1;
      m_data  = res;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    for (int c = 0; c < CH; c++) pend[c] = decode(pins[c*W +: W], ob);
    pend_v = 1;
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".tvalid"}, 64'(tvalid), 64'(m_valid));
    check_eq({tag, ".tdata"}, 64'(tdata), 64'(m_data));
    check_eq({tag, ".ovr"}, 64'(ovr), 64'(m_ovr));
    check_eq({tag, ".ovr_cnt"}, 64'(ovr_cnt), 64'(m_ovr_cnt));
  endtask

  // Called just after a negedge: drive, take the rising edge, compare at the next negedge.
  task automatic cycle(input string tag, input logic [CH*W-1:0] pins, input int cfg,
                       input bit ob, input bit rdy);
    adc_dat = pins;
    cfg_log2_dec = 4'(cfg);
    cfg_offset_bin = ob;
    tready = rdy;
    @(posedge clk);
    model_edge(pins, cfg, ob, rdy);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, ".rst_tvalid"}, 64'(tvalid), 64'd0);
    check_eq({tag, ".rst_tdata"}, 64'(tdata), 64'd0);
    check_eq({tag, ".rst_ovr"}, 64'(ovr), 64'd0);
    check_eq({tag, ".rst_ovr_cnt"}, 64'(ovr_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CH*W-1:0] pins;
    int cfg;
    bit ob, rdy;
    rst_n = 1'b0;
    adc_dat = '0;
    cfg_log2_dec = '0;
    cfg_offset_bin = 1'b0;
    tready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    check_eq("adc_csn", 64'(adc_csn), 64'd1);
    rst_n = 1'b1;

    // Full-rate pass-through with offset-binary conversion
    for (int i = 0; i < 6; i++) cycle("n0_pass", {16'h7FFF, 16'h8005}, 0, 1, 1);

    // Four-sample averages of small positive and negative values
    foreach (pins[i]) pins[i] = 1'b0;
    cycle("n2_a", {16'h0000, 16'd4}, 2, 0, 1);
    cycle("n2_a", {16'h0000, 16'd5}, 2, 0, 1);
    cycle("n2_a", {16'h0000, 16'd6}, 2, 0, 1);
    cycle("n2_a", {16'h0000, 16'd8}, 2, 0, 1);
    cycle("n2_b", {16'h0001, 16'hFFFF}, 2, 0, 1);
    cycle("n2_b", {16'h0001, 16'hFFFF}, 2, 0, 1);
    cycle("n2_b", {16'h0001, 16'hFFFF}, 2, 0, 1);
    cycle("n2_b", {16'h0001, 16'hFFFE}, 2, 0, 1);

    // Largest window at full scale must not wrap; cfg 15 clamps to MAX_LOG2_DEC
    async_reset("pre_n8");
    for (int i = 0; i < 260; i++) cycle("n8_pos", {16'h7FFF, 16'h7FFF}, 8, 0, 1);
    for (int i = 0; i < 260; i++) cycle("n15_neg", {16'h8000, 16'h8000}, 15, 0, 1);

    // Back-pressure: results overwrite and count overruns, then drain
    async_reset("pre_ovr");
    for (int i = 0; i < 6; i++) cycle("ovr_hold", {16'd100, 16'(i * 3)}, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle("ovr_drain", {16'd7, 16'd9}, 1, 0, 1);

    // Window length change mid-window takes effect at the next window
    async_reset("pre_cfg");
    cycle("cfg_chg", {16'd1, 16'd10}, 2, 0, 1);
    cycle("cfg_chg", {16'd2, 16'd20}, 2, 0, 1);
    for (int i = 0; i < 8; i++) cycle("cfg_chg", {16'(i), 16'(i * 5)}, 0, 0, 1);

    // Reset in the middle of a window
    for (int i = 0; i < 3; i++) cycle("mid_win", {16'h1234, 16'h4321}, 3, 1, 1);
    async_reset("mid_win");
    for (int i = 0; i < 12; i++) cycle("post_rst", {16'h0FF0, 16'hF00F}, 3, 1, 1);

    // Randomized traffic
    cfg = 1;
    ob = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 5))
          0: cfg = 0;
          1: cfg = 1;
          2: cfg = 2;
          3: cfg = 3;
          4: cfg = 5;
          default: cfg = 15;
        endcase
        ob = 1'($urandom_range(0, 1));
      end
      rdy = ($urandom_range(0, 3) != 0);
      pins = {16'($urandom), 16'($urandom)};
      cycle("rand", pins, cfg, ob, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
